// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
//   state_e    : controller FSM states
//   SAR_WIDTH  : default searched-value width
//   MSB_ONEHOT : first trial word for the default width
//   is_onehot3 : true when exactly one comparator flag is asserted
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PROBE = 2'b01,
      DONE  = 2'b10
   } state_e;

   localparam int unsigned SAR_WIDTH = 4;
   localparam logic [SAR_WIDTH-1:0] MSB_ONEHOT = 1 << (SAR_WIDTH - 1);

   function automatic logic is_onehot3(input logic eq, input logic lt, input logic gt);
      return ({eq, lt, gt} == 3'b100) || ({eq, lt, gt} == 3'b010) || ({eq, lt, gt} == 3'b001);
   endfunction

endpackage

// File: rtl/sar_search_controller.sv
// Successive-approximation search controller. Drives a trial word onto the B side
// of an external combinational magnitude comparator and resolves one bit per cycle,
// MSB first, stopping early on equality.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a search (accepted only when idle)
//   A_eq_B/A_lt_B/A_gt_B  : comparator flags for the current guess
//   guess                 : registered trial word (comparator B input)
//   busy                  : high while probing
//   done                  : one-cycle completion pulse
//   result, nprobe, error : found value, probe count, non-one-hot flag seen
module sar_search_controller
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH = SAR_WIDTH,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             A_eq_B,
   input  logic             A_lt_B,
   input  logic             A_gt_B,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] nprobe,
   output logic             error
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] nprobe_q, nprobe_d;
   logic             error_q, error_d;
   logic [WIDTH-1:0] acc_new;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         guess_q  <= '0;
         acc_q    <= '0;
         idx_q    <= IDX_TOP;
         result_q <= '0;
         nprobe_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         nprobe_q <= nprobe_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      result_d = result_q;
      nprobe_d = nprobe_q;
      error_d  = error_q;
      // gt keeps the trial bit, lt drops it; the trial word already carries acc.
      acc_new  = A_gt_B ? guess_q : acc_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = PROBE;
               guess_d  = MSB;
               acc_d    = '0;
               idx_d    = IDX_TOP;
               nprobe_d = '0;
               error_d  = 1'b0;
            end
         end
         PROBE: begin
            nprobe_d = nprobe_q + CNT_W'(1);
            if (!is_onehot3(A_eq_B, A_lt_B, A_gt_B)) begin
               error_d  = 1'b1;
               result_d = acc_q;
               state_d  = DONE;
            end else if (A_eq_B) begin
               result_d = guess_q;
               state_d  = DONE;
            end else begin
               acc_d = acc_new;
               if (idx_q == '0) begin
                  result_d = acc_new;
                  state_d  = DONE;
               end else begin
                  idx_d   = idx_q - IDX_W'(1);
                  guess_d = acc_new | (ONE << (idx_q - IDX_W'(1)));
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign guess  = guess_q;
   assign busy   = (state_q == PROBE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign nprobe = nprobe_q;
   assign error  = error_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Self-checking bench for sar_search_controller paired with a 4-bit behavioural
// magnitude comparator. Expected guesses and results are queued per search and
// popped as the controller produces probes and its done pulse.
module tb_sar_search_controller;
   import sar_pkg::*;

   typedef struct packed {
      logic [3:0] result;
      logic [2:0] nprobe;
      logic       error;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] a_val;
   logic       force_en;
   logic [2:0] force_flags;
   logic       a_eq_b, a_lt_b, a_gt_b;
   logic [3:0] guess;
   logic       busy, done, error;
   logic [3:0] result;
   logic [2:0] nprobe;

   logic [3:0] exp_guess_q[$];
   res_t       exp_res_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   // Comparator model, with an override used to inject protocol errors.
   always_comb begin
      if (force_en) begin
         {a_eq_b, a_lt_b, a_gt_b} = force_flags;
      end else begin
         a_eq_b = (a_val == guess);
         a_lt_b = (a_val < guess);
         a_gt_b = (a_val > guess);
      end
   end

   sar_search_controller #(.WIDTH(4), .CNT_W(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .A_eq_B (a_eq_b),
      .A_lt_B (a_lt_b),
      .A_gt_B (a_gt_b),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .result (result),
      .nprobe (nprobe),
      .error  (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a search on target a and consumes probes/done against the scoreboard.
   // force_probe: probe number whose flags are forced to 000 (0 = none).
   // start_probe: probe number during which start is pulsed (0 = none).
   // start_in_done: pulse start during the done cycle and require it to be ignored.
   task automatic run_search(input logic [3:0] a, input int force_probe,
                             input int start_probe, input bit start_in_done);
      bit   finished = 1'b0;
      logic [3:0] eg;
      res_t er;
      a_val = a;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 20 && !finished; c++) begin
         force_en    = (c == force_probe);
         force_flags = 3'b000;
         start       = (c == start_probe);
         if (busy) begin
            n_cmp++;
            if (exp_guess_q.size() == 0) begin
               n_bad++;
               $display("FAIL extra_probe a=%b: got guess %b in probe %0d, required none", a, guess, c);
            end else begin
               eg = exp_guess_q.pop_front();
               if (guess !== eg) begin
                  n_bad++;
                  $display("FAIL guess a=%b probe %0d: got %b, required %b", a, c, guess, eg);
               end
            end
         end else if (done) begin
            finished = 1'b1;
            er = exp_res_q.pop_front();
            n_cmp++;
            if (result !== er.result) begin
               n_bad++;
               $display("FAIL result a=%b: got %b, required %b", a, result, er.result);
            end
            n_cmp++;
            if (nprobe !== er.nprobe) begin
               n_bad++;
               $display("FAIL nprobe a=%b: got %0d, required %0d", a, nprobe, er.nprobe);
            end
            n_cmp++;
            if (error !== er.error) begin
               n_bad++;
               $display("FAIL error a=%b: got %b, required %b", a, error, er.error);
            end
            n_cmp++;
            if (c != int'(er.nprobe) + 1) begin
               n_bad++;
               $display("FAIL latency a=%b: got done %0d cycles after start, required %0d",
                        a, c, int'(er.nprobe) + 1);
            end
         end else begin
            finished = 1'b1;
            n_cmp++;
            n_bad++;
            $display("FAIL idle_midsearch a=%b: got busy=0 done=0 at cycle %0d, required busy or done",
                     a, c);
         end
         if (!finished) tick();
      end
      force_en = 1'b0;
      start    = start_in_done;
      if (!finished) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout a=%b: got no done in 20 cycles, required done", a);
      end
      n_cmp++;
      if (exp_guess_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_probes a=%b: got %0d unconsumed, required 0", a, exp_guess_q.size());
         exp_guess_q.delete();
      end
      tick();
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL back_to_idle a=%b: got busy=%b done=%b, required 0 0", a, busy, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({busy, done, error} !== 3'b000 || guess !== 4'd0 || result !== 4'd0 || nprobe !== 3'd0)
      begin
         n_bad++;
         $display("FAIL reset_state: got busy=%b done=%b error=%b guess=%b result=%b nprobe=%0d, required all 0",
                  busy, done, error, guess, result, nprobe);
      end
   endtask

   task automatic test_early_exit();
      exp_guess_q.push_back(MSB_ONEHOT);
      exp_res_q.push_back('{result: 4'b1000, nprobe: 3'd1, error: 1'b0});
      run_search(4'b1000, 0, 0, 1'b0);
   endtask

   task automatic test_four_step();
      exp_guess_q.push_back(4'b1000);
      exp_guess_q.push_back(4'b1100);
      exp_guess_q.push_back(4'b1010);
      exp_guess_q.push_back(4'b1011);
      exp_res_q.push_back('{result: 4'b1011, nprobe: 3'd4, error: 1'b0});
      run_search(4'b1011, 0, 0, 1'b0);
      tick();
      n_cmp++;
      if (result !== 4'b1011) begin
         n_bad++;
         $display("FAIL result_hold: got %b, required 1011", result);
      end
   endtask

   task automatic test_all_lt();
      exp_guess_q.push_back(4'b1000);
      exp_guess_q.push_back(4'b0100);
      exp_guess_q.push_back(4'b0010);
      exp_guess_q.push_back(4'b0001);
      exp_res_q.push_back('{result: 4'b0000, nprobe: 3'd4, error: 1'b0});
      run_search(4'b0000, 0, 0, 1'b0);
   endtask

   task automatic test_all_gt();
      exp_guess_q.push_back(4'b1000);
      exp_guess_q.push_back(4'b1100);
      exp_guess_q.push_back(4'b1110);
      exp_guess_q.push_back(4'b1111);
      exp_res_q.push_back('{result: 4'b1111, nprobe: 3'd4, error: 1'b0});
      run_search(4'b1111, 0, 0, 1'b0);
   endtask

   task automatic test_error_and_ignored_start();
      exp_guess_q.push_back(4'b1000);
      exp_guess_q.push_back(4'b0100);
      exp_res_q.push_back('{result: 4'b0000, nprobe: 3'd2, error: 1'b1});
      run_search(4'b0110, 2, 0, 1'b0);
      // Start pulses during probe 2 and during done must both be ignored.
      exp_guess_q.push_back(4'b1000);
      exp_guess_q.push_back(4'b1100);
      exp_guess_q.push_back(4'b1010);
      exp_guess_q.push_back(4'b1011);
      exp_res_q.push_back('{result: 4'b1011, nprobe: 3'd4, error: 1'b0});
      run_search(4'b1011, 0, 2, 1'b1);
   endtask

   task automatic test_reset_mid_search();
      a_val = 4'b0101;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      // Now in probe 3.
      n_cmp++;
      if (busy !== 1'b1 || guess !== 4'b0110) begin
         n_bad++;
         $display("FAIL probe3_state: got busy=%b guess=%b, required 1 0110", busy, guess);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || guess !== 4'd0 || result !== 4'd0) begin
         n_bad++;
         $display("FAIL mid_reset: got busy=%b done=%b guess=%b result=%b, required 0 0 0000 0000",
                  busy, done, guess, result);
      end
      exp_guess_q.push_back(4'b1000);
      exp_guess_q.push_back(4'b0100);
      exp_guess_q.push_back(4'b0110);
      exp_guess_q.push_back(4'b0101);
      exp_res_q.push_back('{result: 4'b0101, nprobe: 3'd4, error: 1'b0});
      run_search(4'b0101, 0, 0, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      a_val       = 4'd0;
      force_en    = 1'b0;
      force_flags = 3'b000;
      test_reset();
      test_early_exit();
      test_four_step();
      test_all_lt();
      test_all_gt();
      test_error_and_ignored_start();
      test_reset_mid_search();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
